fcvt_pipe: RTL and testbench
============================

FCVT_PIPE -- requirements
Module: fcvt_pipe

Interface
REQ-001 SHALL have parameter W, default 32, output integer width; legal values 32 and 64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in cycles; legal values 1 to 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, an input operand is presented.
REQ-006 SHALL have port in_ready, output, 1, the block accepts an operand this cycle.
REQ-007 SHALL have port x, input, 32, the IEEE-754 binary32 operand.
REQ-008 SHALL have port rm, input, 3, rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 SHALL have port uns, input, 1, 1 selects an unsigned result, 0 selects a signed result.
REQ-010 SHALL have port out_valid, output, 1, the result is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port y, output, W, the integer result.
REQ-013 SHALL have port nv, output, 1, invalid-operation flag.
REQ-014 SHALL have port nx, output, 1, inexact flag.

Function
REQ-015 SHALL accept an operand on a cycle with in_valid && in_ready, and SHALL complete a transfer on a cycle with out_valid && out_ready.
REQ-016 SHALL set in_ready = out_ready || !out_valid (global stall).
REQ-017 SHALL, while stalled, hold every stage, y, nv, nx and out_valid; no operand SHALL be lost or duplicated.
REQ-018 SHALL assert out_valid exactly STAGES cycles after acceptance when out_ready is held high; throughput SHALL be 1 result per cycle; results SHALL leave in order.
REQ-019 SHALL carry uns and rm per transaction alongside x.
REQ-020 SHALL treat rm values 101, 110 and 111 as RNE.
REQ-021 SHALL round the exact value of x to an integer per rm; RMM rounds ties away from zero.
REQ-022 SHALL, on NaN input, give y = the maximum for the mode (2^(W-1)-1 signed, 2^W-1 unsigned) with nv=1.
REQ-023 SHALL, on +inf or a rounded value above the maximum, give y = the maximum with nv=1.
REQ-024 SHALL, in signed mode on -inf or a rounded value below -2^(W-1), give y = -2^(W-1) with nv=1.
REQ-025 SHALL, in unsigned mode on any rounded value below 0 (including -inf), give y = 0 with nv=1; a negative input that rounds to 0 SHALL give nv=0.
REQ-026 SHALL force nx=0 whenever nv=1; +0, -0 and subnormals SHALL follow the normal rounding rules (RUP on the smallest positive subnormal gives 1).

Reset
REQ-027 SHALL, with rst high at a clock edge, clear all stage valid bits so that out_valid=0 and y=0, nv=0, nx=0 on the following cycle.
REQ-028 SHALL discard any in-flight operands on reset mid-operation, and SHALL drive in_ready=1 in the cycle after reset.

Configuration
REQ-029 SHALL, with macro FCVT_INEXACT_EN defined, compute nx=1 whenever the result differs from the exact value and nv=0.
REQ-030 SHALL, without FCVT_INEXACT_EN, tie nx to 0 and omit the sticky/guard logic; y and nv SHALL be unchanged.

Verification
REQ-031 SHALL cover: W=32, x=0x3FC00000 (1.5), signed -> RNE y=2, RTZ y=1, RDN y=1, RUP y=2, each with nx=1 and nv=0.
REQ-032 SHALL cover: x=0x40200000 (2.5) -> RNE y=2 and RMM y=3; x=0xC0200000 (-2.5) -> RMM y=-3 and RDN y=-3.
REQ-033 SHALL cover: W=32, x=0x4F000000 -> signed y=0x7FFFFFFF with nv=1, unsigned y=0x80000000 with nv=0; x=0xCF000000 -> signed y=0x80000000 with nv=0.
REQ-034 SHALL cover: x=0x7FC00000 -> signed y=0x7FFFFFFF with nv=1; x=0xBF000000 (-0.5) unsigned -> RTZ y=0 with nv=0 and nx=1, RDN y=0 with nv=1 and nx=0.
REQ-035 SHALL cover: STAGES=3, back-to-back inputs 1.0, 2.0, 3.0, 4.0 with out_ready low for 2 cycles mid-stream -> outputs 1, 2, 3, 4 in order, y held during the stall, in_ready=0 while stalled.
REQ-036 SHALL cover: W=64, x=0x5F000000 (2^63) -> signed y=0x7FFFFFFFFFFFFFFF with nv=1; reset asserted with 2 operands in flight -> out_valid=0 the next cycle and no stale result afterwards.

Source files
------------

// File: rtl/fcvt_pipe.sv
// fcvt_pipe: IEEE-754 binary32 to W-bit integer conversion (signed or unsigned),
// all five RISC-V rounding modes, saturating with an invalid flag.
// The conversion is combinational at the input. Its result then moves through
// STAGES registers that share one stall enable (in_ready).
// Optional macro FCVT_INEXACT_EN: when it is defined, nx reports inexact results.
// When it is not defined, nx is tied low.
module fcvt_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  x,
    input  logic [2:0]   rm,
    input  logic         uns,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         nv,
    output logic         nx
);
    // 65 bits is wide enough for any in-range magnitude plus the carry out of rounding.
    localparam int MW = 65;
    // 2^(W-1): the signed range limit
    localparam logic [MW-1:0] HALF_RANGE = {{(MW-1){1'b0}}, 1'b1} << (W - 1);

    logic          sgn, is_nan, is_inf, big, rnd, stk, inc;
    logic [7:0]    ee, sh, rs;
    logic [4:0]    rpos;
    logic [23:0]   mant;
    logic [MW-1:0] ipart, mag;
    logic [W-1:0]  res_y;
    logic          res_nv, res_nx;

    // Decode, align, round and saturate the presented operand
    always_comb begin
        sgn    = x[31];
        is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        is_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        // Subnormals use exponent 1 and have no hidden bit.
        ee     = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        mant   = {(x[30:23] != 8'd0), x[22:0]};
        sh     = '0;
        rs     = '0;
        rpos   = '0;
        big    = 1'b0;
        rnd    = 1'b0;
        stk    = 1'b0;
        ipart  = '0;
        // Value is mant * 2^(ee-150)
        if (ee >= 8'd150) begin
            sh = ee - 8'd150;
            // A shift beyond 40 puts the value at 2^63 or more. That exceeds every W=32/64 range.
            if (sh > 8'd40) begin
                big = 1'b1;
            end else begin
                ipart = {{(MW-24){1'b0}}, mant} << sh;
            end
        end else begin
            rs = 8'd150 - ee;
            if (rs > 8'd24) begin
                // The value is below one half, so every set bit lands in the sticky bit.
                stk = |mant;
            end else begin
                rpos  = 5'(rs - 8'd1);
                ipart = {{(MW-24){1'b0}}, mant >> rs};
                rnd   = mant[rpos];
                stk   = |(mant & ((24'd1 << rpos) - 24'd1));
            end
        end

        // Round the magnitude. Directed modes depend on the sign. Reserved encodings act as RNE.
        case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (rnd | stk);
            3'b011:  inc = ~sgn & (rnd | stk);
            3'b100:  inc = rnd;
            default: inc = rnd & (stk | ipart[0]);
        endcase
        mag = ipart + {{(MW-1){1'b0}}, inc};

        // Saturate to the selected integer range
        res_y  = '0;
        res_nv = 1'b0;
        if (is_nan) begin
            res_nv = 1'b1;
            res_y  = uns ? {W{1'b1}} : {1'b0, {(W-1){1'b1}}};
        end else if (uns) begin
            if (sgn) begin
                // A negative value that rounds to zero is legal. Anything below zero clamps to 0.
                if (is_inf || big || (mag != '0)) begin
                    res_nv = 1'b1;
                end
            end else if (is_inf || big || ((mag >> W) != '0)) begin
                res_nv = 1'b1;
                res_y  = {W{1'b1}};
            end else begin
                res_y = mag[W-1:0];
            end
        end else begin
            if (!sgn) begin
                if (is_inf || big || (mag >= HALF_RANGE)) begin
                    res_nv = 1'b1;
                    res_y  = {1'b0, {(W-1){1'b1}}};
                end else begin
                    res_y = mag[W-1:0];
                end
            end else begin
                if (is_inf || big || (mag > HALF_RANGE)) begin
                    res_nv = 1'b1;
                    res_y  = {1'b1, {(W-1){1'b0}}};
                end else begin
                    res_y = -mag[W-1:0];
                end
            end
        end

`ifdef FCVT_INEXACT_EN
        res_nx = ~res_nv & (rnd | stk);
`else
        res_nx = 1'b0;
`endif
    end

    logic         v_reg  [1:STAGES];
    logic [W-1:0] y_reg  [1:STAGES];
    logic         nv_reg [1:STAGES];
    logic         nx_reg [1:STAGES];

    assign out_valid = v_reg[STAGES];
    assign y         = y_reg[STAGES];
    assign nv        = nv_reg[STAGES];
    assign nx        = nx_reg[STAGES];
    // The pipeline stalls as a unit. It moves only while the output can drain or is empty.
    assign in_ready  = out_ready || !out_valid;

    // Stage registers. Reset drops in-flight work. A stall freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= STAGES; i++) begin
                v_reg[i]  <= 1'b0;
                y_reg[i]  <= '0;
                nv_reg[i] <= 1'b0;
                nx_reg[i] <= 1'b0;
            end
        end else if (in_ready) begin
            v_reg[1]  <= in_valid;
            y_reg[1]  <= res_y;
            nv_reg[1] <= res_nv;
            nx_reg[1] <= res_nx;
            for (int i = 2; i <= STAGES; i++) begin
                v_reg[i]  <= v_reg[i-1];
                y_reg[i]  <= y_reg[i-1];
                nv_reg[i] <= nv_reg[i-1];
                nx_reg[i] <= nx_reg[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fcvt_pipe.sv
// tb_fcvt_pipe: this bench drives two fcvt_pipe instances.
// One is W=32/STAGES=3 and the other is W=64/STAGES=2.
// Both are checked against a real-arithmetic reference model.
// Expected nx follows FCVT_INEXACT_EN.
module tb_fcvt_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x;
    logic [2:0]  rm;
    logic        uns;
    logic        iv32, ir32, ov32, or32, nv32, nx32;
    logic [31:0] y32;
    logic        iv64, ir64, ov64, or64, nv64, nx64;
    logic [63:0] y64;
    int          nerr = 0;
    int          nchk = 0;

    always #5 clk = ~clk;

    fcvt_pipe #(.W(32), .STAGES(3)) d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x), .rm(rm), .uns(uns),
        .out_valid(ov32), .out_ready(or32), .y(y32), .nv(nv32), .nx(nx32)
    );
    fcvt_pipe #(.W(64), .STAGES(2)) d64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .x(x), .rm(rm), .uns(uns),
        .out_valid(ov64), .out_ready(or64), .y(y64), .nv(nv64), .nx(nx64)
    );

    typedef struct {
        logic [31:0] xv;
        logic [2:0]  rmv;
        logic        u;
        logic [31:0] ey;
        logic        env;
    } vec_t;

    vec_t dv [20] = '{
        '{32'h3FC00000, 3'd0, 1'b0, 32'd2,        1'b0},
        '{32'h3FC00000, 3'd1, 1'b0, 32'd1,        1'b0},
        '{32'h3FC00000, 3'd2, 1'b0, 32'd1,        1'b0},
        '{32'h3FC00000, 3'd3, 1'b0, 32'd2,        1'b0},
        '{32'h40200000, 3'd0, 1'b0, 32'd2,        1'b0},
        '{32'h40200000, 3'd4, 1'b0, 32'd3,        1'b0},
        '{32'hC0200000, 3'd4, 1'b0, 32'hFFFFFFFD, 1'b0},
        '{32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0},
        '{32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1},
        '{32'h4F000000, 3'd0, 1'b1, 32'h80000000, 1'b0},
        '{32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0},
        '{32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1},
        '{32'hBF000000, 3'd1, 1'b1, 32'd0,        1'b0},
        '{32'hBF000000, 3'd2, 1'b1, 32'd0,        1'b1},
        '{32'h5F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1},
        '{32'h00000001, 3'd3, 1'b0, 32'd1,        1'b0},
        '{32'h80000000, 3'd2, 1'b1, 32'd0,        1'b0},
        '{32'hFF800000, 3'd0, 1'b1, 32'd0,        1'b1},
        '{32'h40200000, 3'd6, 1'b0, 32'd2,        1'b0},
        '{32'h3FC00000, 3'd5, 1'b0, 32'd2,        1'b0}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the exact real value, rounded with floor/ceil, then clamped to the range.
    task automatic ref_cvt(input logic [31:0] xv, input logic [2:0] rmv, input logic u, input int w,
                           output logic [63:0] ry, output logic rnv, output logic rnx);
        real r, fl, d, q, lo, hi;
        int  ex, mnt;
        logic [63:0] umax, smax, smin;
        umax = (w == 64) ? 64'hFFFFFFFFFFFFFFFF : ((64'd1 << w) - 64'd1);
        smax = (64'd1 << (w - 1)) - 64'd1;
        smin = 64'd1 << (w - 1);
        rnv  = 1'b0;
        rnx  = 1'b0;
        ry   = '0;
        ex   = int'({24'd0, xv[30:23]});
        mnt  = int'({9'd0, xv[22:0]});
        if (ex == 255) begin
            rnv = 1'b1;
            if (xv[22:0] != 23'd0 || !xv[31]) ry = u ? umax : smax;
            else                              ry = u ? 64'd0 : smin;
        end else begin
            if (ex != 0) mnt = mnt + 8388608;
            else         ex = 1;
            r = real'(mnt) * (2.0 ** (ex - 150));
            if (xv[31]) r = -r;
            fl = $floor(r);
            d  = r - fl;
            case (rmv)
                3'd1:    q = (r >= 0.0) ? fl : $ceil(r);
                3'd2:    q = fl;
                3'd3:    q = $ceil(r);
                3'd4:    q = (d > 0.5 || (d == 0.5 && r > 0.0)) ? fl + 1.0 : fl;
                default: q = (d > 0.5 || (d == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) ? fl + 1.0 : fl;
            endcase
            lo = u ? 0.0 : -(2.0 ** (w - 1));
            hi = u ? (2.0 ** w) : (2.0 ** (w - 1));
            if (q >= hi) begin
                rnv = 1'b1;
                ry  = u ? umax : smax;
            end else if (q < lo) begin
                rnv = 1'b1;
                ry  = u ? 64'd0 : smin;
            end else begin
                if (q >= 2.0 ** 63) begin
                    ry     = longint'(q - 2.0 ** 63);
                    ry[63] = 1'b1;
                end else begin
                    ry = longint'(q);
                end
`ifdef FCVT_INEXACT_EN
                rnx = (q != r);
`endif
            end
        end
    endtask

    // Present one operand to both instances and collect each result. Latency and values are checked.
    task automatic run_op(input logic [31:0] xv, input logic [2:0] rmv, input logic u, input string tag,
                          output logic [31:0] gy32, output logic gnv32);
        logic [63:0] e32, e64, gy64;
        logic        env32, enx32, env64, enx64, gnx32, gnv64, gnx64;
        int          lat32, lat64;
        ref_cvt(xv, rmv, u, 32, e32, env32, enx32);
        ref_cvt(xv, rmv, u, 64, e64, env64, enx64);
        gy32 = '0; gnv32 = 1'b0; gnx32 = 1'b0;
        gy64 = '0; gnv64 = 1'b0; gnx64 = 1'b0;
        lat32 = 0; lat64 = 0;
        x = xv; rm = rmv; uns = u; iv32 = 1'b1; iv64 = 1'b1;
        #1;
        check({tag, " in_ready"}, {62'd0, ir32, ir64}, 64'd3);
        @(posedge clk); #1;
        iv32 = 1'b0; iv64 = 1'b0;
        #1;
        for (int c = 1; c <= 8; c++) begin
            if (ov32 && lat32 == 0) begin
                lat32 = c; gy32 = y32; gnv32 = nv32; gnx32 = nx32;
            end
            if (ov64 && lat64 == 0) begin
                lat64 = c; gy64 = y64; gnv64 = nv64; gnx64 = nx64;
            end
            @(posedge clk); #2;
        end
        check({tag, " lat32"}, 64'(lat32), 64'd3);
        check({tag, " lat64"}, 64'(lat64), 64'd2);
        check({tag, " y32"},  {32'd0, gy32}, {32'd0, e32[31:0]});
        check({tag, " nv32"}, {63'd0, gnv32}, {63'd0, env32});
        check({tag, " nx32"}, {63'd0, gnx32}, {63'd0, enx32});
        check({tag, " y64"},  gy64, e64);
        check({tag, " nv64"}, {63'd0, gnv64}, {63'd0, env64});
        check({tag, " nx64"}, {63'd0, gnx64}, {63'd0, enx64});
        $display("op %s x=%h rm=%0d uns=%0b -> y32=%h nv32=%0b y64=%h nv64=%0b",
                 tag, xv, rmv, u, gy32, gnv32, gy64, gnv64);
    endtask

    initial begin
        logic [31:0] gy, held_y;
        logic        gnv, stalled_prev, accepted;
        logic [31:0] xs [4];
        logic [7:0]  ex;
        int          sent, rcvd;

        rst = 1'b1; x = '0; rm = '0; uns = 1'b0;
        iv32 = 1'b0; iv64 = 1'b0; or32 = 1'b1; or64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset out_valid", {62'd0, ov32, ov64}, 64'd0);
        check("reset y32", {32'd0, y32}, 64'd0);
        check("reset y64", y64, 64'd0);
        check("reset flags", {60'd0, nv32, nx32, nv64, nx64}, 64'd0);
        check("reset in_ready", {62'd0, ir32, ir64}, 64'd3);

        // Directed vectors from the datasheet. The W=32 result is also checked against a constant.
        for (int i = 0; i < 20; i++) begin
            run_op(dv[i].xv, dv[i].rmv, dv[i].u, $sformatf("dir%0d", i), gy, gnv);
            check($sformatf("dir%0d y32 const", i), {32'd0, gy}, {32'd0, dv[i].ey});
            check($sformatf("dir%0d nv32 const", i), {63'd0, gnv}, {63'd0, dv[i].env});
        end

        // Random operands. Most exponents fall in the interesting range, with some zero/inf/nan.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       ex = 8'd0;
                1:       ex = 8'hFF;
                default: ex = 8'($urandom_range(110, 192));
            endcase
            run_op({1'($urandom_range(0, 1)), ex, 23'($urandom)}, 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), gy, gnv);
        end

        // Streaming with a two-cycle output stall on the 3-stage instance
        xs[0] = 32'h3F800000; xs[1] = 32'h40000000; xs[2] = 32'h40400000; xs[3] = 32'h40800000;
        sent = 0; rcvd = 0; stalled_prev = 1'b0; held_y = '0;
        rm = 3'd0; uns = 1'b0; iv64 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            or32 = !(k == 4 || k == 5);
            iv32 = (sent < 4);
            if (sent < 4) x = xs[sent];
            #1;
            if (stalled_prev) begin
                check($sformatf("stall hold y k%0d", k), {32'd0, y32}, {32'd0, held_y});
                check($sformatf("stall hold valid k%0d", k), {63'd0, ov32}, 64'd1);
            end
            if (ov32 && !or32) check($sformatf("stall in_ready k%0d", k), {63'd0, ir32}, 64'd0);
            if (ov32 && or32) begin
                check($sformatf("stream out%0d", rcvd), {32'd0, y32}, 64'(rcvd + 1));
                $display("stream k=%0d y32=%0d", k, y32);
                rcvd++;
            end
            stalled_prev = ov32 && !or32;
            held_y = y32;
            accepted = iv32 && ir32;
            @(posedge clk); #1;
            if (accepted) sent++;
        end
        check("stream sent", 64'(sent), 64'd4);
        check("stream received", 64'(rcvd), 64'd4);
        or32 = 1'b1; iv32 = 1'b0;

        // Reset while two operands are in flight
        x = 32'h3F800000; rm = 3'd0; uns = 1'b0; iv32 = 1'b1; iv64 = 1'b1;
        @(posedge clk); #1;
        x = 32'h40000000;
        @(posedge clk); #1;
        iv32 = 1'b0; iv64 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset out_valid", {62'd0, ov32, ov64}, 64'd0);
        check("midreset y", {32'd0, y32} | y64, 64'd0);
        check("midreset flags", {60'd0, nv32, nx32, nv64, nx64}, 64'd0);
        check("midreset in_ready", {62'd0, ir32, ir64}, 64'd3);
        $display("reset mid-operation: out_valid32=%0b out_valid64=%0b", ov32, ov64);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            check($sformatf("no stale c%0d", c), {62'd0, ov32, ov64}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
